// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHalt
    } fetch_state_e;

    localparam int unsigned INSTR_WIDTH_DEFAULT = 16;

    // PC width for a given memory depth; at least one bit even for a single-word memory.
    function automatic int unsigned pc_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: instruction memory port, downstream valid/ready channel and redirect request.
interface fetch_if #(
    parameter int unsigned PC_WIDTH    = 2,
    parameter int unsigned INSTR_WIDTH = fetch_pkg::INSTR_WIDTH_DEFAULT
);
    logic [PC_WIDTH-1:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [PC_WIDTH-1:0]    out_pc;
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;

    modport master (
        output imem_addr, out_valid, out_instr, out_pc,
        input  imem_rdata, out_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_addr, out_valid, out_instr, out_pc,
        output imem_rdata, out_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_pc_gen.sv
// Program counter: increment with explicit wrap at the last word, redirect folded into range.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 4,
    parameter int unsigned PC_WIDTH   = pc_width(IMEM_DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance_i,
    input  logic                redirect_valid_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                last_o
);
    localparam logic [PC_WIDTH:0]   DEPTH_EXT = (PC_WIDTH + 1)'(IMEM_DEPTH);
    localparam logic [PC_WIDTH-1:0] LAST_PC   = PC_WIDTH'(IMEM_DEPTH - 1);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH:0]   redir_ext;

    // A PC_WIDTH value is below 2*IMEM_DEPTH, so one conditional subtract is a full modulo.
    always_comb begin
        redir_ext = {1'b0, redirect_pc_i};
        target    = redirect_pc_i;
        if (redir_ext >= DEPTH_EXT) begin
            target = PC_WIDTH'(redir_ext - DEPTH_EXT);
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = target;
        end else if (advance_i) begin
            pc_d = (pc_q == LAST_PC) ? '0 : pc_q + PC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o   = pc_q;
    assign last_o = (pc_q == LAST_PC);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/RUN/HALT control plus a one-entry output register.
// Define FETCH_WRAP_EN to wrap the PC and fetch forever instead of halting after the last word.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH  = 4,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEFAULT
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    start,
    output logic    busy,
    output logic    done,
    fetch_if.master bus
);
    localparam int unsigned PC_WIDTH = pc_width(IMEM_DEPTH);
`ifdef FETCH_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    fetch_state_e           state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [INSTR_WIDTH-1:0] out_instr_q, out_instr_d;
    logic [PC_WIDTH-1:0]    out_pc_q, out_pc_d;
    logic [PC_WIDTH-1:0]    pc;
    logic                   pc_last;
    logic                   fire;

    // Redirect wins over a fetch in the same cycle.
    assign fire = (state_q == StRun) && (!out_valid_q || bus.out_ready) && !bus.redirect_valid;

    fetch_pc_gen #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .PC_WIDTH   (PC_WIDTH)
    ) u_pc_gen (
        .clk              (clk),
        .reset            (reset),
        .advance_i        (fire),
        .redirect_valid_i (bus.redirect_valid),
        .redirect_pc_i    (bus.redirect_pc),
        .pc_o             (pc),
        .last_o           (pc_last)
    );

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        if (bus.redirect_valid) begin
            state_d     = StRun;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (fire && pc_last && !WRAP_EN) state_d = StHalt;
                default: ;
            endcase
            if (fire) begin
                out_valid_d = 1'b1;
                out_instr_d = bus.imem_rdata;
                out_pc_d    = pc;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
        end
    end

    assign busy          = (state_q == StRun);
    assign done          = (state_q == StHalt);
    assign bus.imem_addr = pc;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_instr_q;
    assign bus.out_pc    = out_pc_q;

endmodule
